// File: rtl/mult_arbiter_pkg.sv
// Shared types and constants for the round-robin multiplier arbiter.
// Holds the result-slot FSM encoding and the delivered-result counter width.
package mult_arbiter_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int CNT_W = 16;

endpackage

// File: rtl/mult_arbiter_rr_arbiter.sv
// Round-robin grant: first requester at or above ptr, wrapping to 0.
// Produces a one-hot grant and its encoded index.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int IW = $clog2(NREQ);

    logic found;
    int   c;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < NREQ; k++) begin
            c = (int'(ptr) + k) % NREQ;
            if (!found && req[c]) begin
                grant[c] = 1'b1;
                idx      = IW'(c);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbitrated signed multiplier with a single registered result
// slot, valid/ready on both sides and a wrapping delivered-result counter.
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int N    = 9,
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*N-1:0]       req_x1,
    input  logic [NREQ*N-1:0]       req_x2,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [2*N-1:0]          res_y,
    output logic [$clog2(NREQ)-1:0] res_id,
    output logic [CNT_W-1:0]        ops_cnt
);

    localparam int IW = $clog2(NREQ);

    state_t               state;
    logic [IW-1:0]        rr_ptr;
    logic [NREQ-1:0]      grant;
    logic [IW-1:0]        gidx;
    logic                 slot_free;
    logic                 accept;
    logic                 xfer;
    logic signed [N-1:0]  x1_g;
    logic signed [N-1:0]  x2_g;
    logic signed [2*N-1:0] prod;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gidx)
    );

    assign res_valid = (state == FULL);
    assign slot_free = !res_valid || res_ready;
    assign xfer      = res_valid && res_ready;

    // Reset also gates the grant so nothing is handshaken while held in reset.
    assign req_ready = (slot_free && !rst) ? grant : '0;
    assign accept    = |req_ready;

    always_comb begin
        x1_g = req_x1[gidx*N +: N];
        x2_g = req_x2[gidx*N +: N];
    end

    assign prod = (2*N)'(x1_g) * (2*N)'(x2_g);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            res_y   <= '0;
            res_id  <= '0;
            rr_ptr  <= '0;
            ops_cnt <= '0;
        end else begin
            if (accept) begin
                state  <= FULL;
                res_y  <= prod;
                res_id <= gidx;
                rr_ptr <= (gidx == IW'(NREQ-1)) ? '0 : gidx + 1'b1;
            end else if (xfer) begin
                state <= EMPTY;
            end
            if (xfer) begin
                ops_cnt <= ops_cnt + 1'b1;
            end
        end
    end

endmodule
